// File: rtl/intersection_phase_scheduler.sv
// Round-robin green-phase scheduler for an N-approach intersection.
// Each handover runs green -> yellow -> all-red on a prescaled tick. Approach 0
// is the home approach and rests in green when nobody else is waiting. An
// emergency pre-emption input forces the junction to all-red and holds it there.
module intersection_phase_scheduler #(
   parameter int N_APPR    = 4,
   parameter int TICK_DIV  = 4,
   parameter int GREEN_MIN = 10,
   parameter int GREEN_MAX = 30,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int CNT_W     = 8,
   localparam int AW       = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_APPR-1:0]     req,
   input  logic                  preempt,
   output logic [2*N_APPR-1:0]   sig,
   output logic [AW-1:0]         active,
   output logic [1:0]            phase,
   output logic                  grant_pulse
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0]    P_LAST      = PW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] T_GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] T_GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] T_GMAX      = CNT_W'(GREEN_MAX);
   localparam logic [CNT_W-1:0] T_YEL_LAST  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] T_AR_LAST   = CNT_W'(ALLRED_T - 1);

   // Encoding doubles as the phase output code.
   typedef enum logic [1:0] {
      S_GREEN   = 2'b00,
      S_YELLOW  = 2'b01,
      S_ALL_RED = 2'b10
   } state_t;

   state_t             state, state_n;
   logic [PW-1:0]      presc;
   logic [CNT_W-1:0]   timer;
   logic [AW-1:0]      active_n, next_owner, idx;
   logic [N_APPR-1:0]  other_mask;
   logic               tick, other_req, green_done, found;

   // Lamp pattern for a given phase and owner: only the owner may be non-red.
   function automatic logic [2*N_APPR-1:0] lamp_decode(input state_t st,
                                                       input logic [AW-1:0] owner);
      logic [2*N_APPR-1:0] v;
      v = '1;
      for (int k = 0; k < N_APPR; k++) begin
         if (AW'(k) == owner) begin
            case (st)
               S_GREEN:  v[2*k +: 2] = 2'b01;
               S_YELLOW: v[2*k +: 2] = 2'b10;
               default:  v[2*k +: 2] = 2'b11;
            endcase
         end
      end
      return v;
   endfunction

   // Round-robin search starting after the current owner; the owner is tried last.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      next_owner = '0;
      found      = 1'b0;
      idx        = '0;
      for (int i = 1; i <= N_APPR; i++) begin
         idx = AW'((int'(active) + i) % N_APPR);
         if (!found && req[idx]) begin
            next_owner = idx;
            found      = 1'b1;
         end
      end
   end

   // Tick, competing-demand and green-exit qualifiers.
   always_comb begin
      tick               = (presc == P_LAST);
      other_mask         = req;
      other_mask[active] = 1'b0;
      other_req          = |other_mask;
      // The max-green test uses >= so a timer already saturated at GREEN_MAX
      // still yields to a late-arriving competitor.
      green_done = tick && (timer >= T_GMIN_LAST) &&
                   ((other_req && !req[active]) ||
                    (other_req && (timer >= T_GMAX_LAST)) ||
                    ((active != '0) && (req == '0)));
   end

   // Next phase and next owner.
   always_comb begin
      state_n  = state;
      active_n = active;
      case (state)
         S_GREEN: begin
            if (preempt || green_done) state_n = S_YELLOW;
         end
         S_YELLOW: begin
            if (tick && (timer == T_YEL_LAST)) state_n = S_ALL_RED;
         end
         S_ALL_RED: begin
            if (!preempt && tick && (timer == T_AR_LAST)) begin
               state_n  = S_GREEN;
               active_n = next_owner;
            end
         end
         default: state_n = S_ALL_RED;
      endcase
   end

   // State, timing and registered outputs; outputs are decoded from the next
   // state so they change on the same edge as the state itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_ALL_RED;
         active      <= '0;
         timer       <= '0;
         presc       <= '0;
         sig         <= '1;
         phase       <= S_ALL_RED;
         grant_pulse <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
         state <= state_n;
         active <= active_n;
         if (state_n != state) begin
            timer <= '0;
         end else if ((state == S_ALL_RED) && preempt) begin
            // Clearance restarts from zero once pre-emption is released.
            timer <= '0;
         end else if (tick && (timer != T_GMAX)) begin
            timer <= timer + 1'b1;
         end
         sig         <= lamp_decode(state_n, active_n);
         phase       <= state_n;
         grant_pulse <= (state_n == S_GREEN) && (state != S_GREEN);
      end
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler: directed scenarios from
// the timing rules plus a randomized run against a tick-counting reference model.
module tb_intersection_phase_scheduler;

   localparam int N_APPR    = 4;
   localparam int TICK_DIV  = 4;
   localparam int GREEN_MIN = 10;
   localparam int GREEN_MAX = 30;
   localparam int YELLOW_T  = 3;
   localparam int ALLRED_T  = 1;
   localparam int CNT_W     = 8;
   localparam int AW        = $clog2(N_APPR);
   localparam int VW        = 2*N_APPR + 2 + AW + 1;

   logic                 clk     = 1'b0;
   logic                 rst     = 1'b1;
   logic [N_APPR-1:0]    req     = '0;
   logic                 preempt = 1'b0;
   logic [2*N_APPR-1:0]  sig;
   logic [AW-1:0]        active;
   logic [1:0]           phase;
   logic                 grant_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   intersection_phase_scheduler #(
      .N_APPR(N_APPR), .TICK_DIV(TICK_DIV), .GREEN_MIN(GREEN_MIN),
      .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .preempt(preempt),
      .sig(sig), .active(active), .phase(phase), .grant_pulse(grant_pulse)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // m_state: 0 green, 1 yellow, 2 all-red. m_ticks counts whole ticks spent
   // in the current phase; m_cyc counts clock edges since reset release.
   int m_state = 2;
   int m_active = 0;
   int m_ticks = 0;
   int m_cyc = 0;
   bit m_grant = 1'b0;

   function automatic int pick_next(input int from, input logic [N_APPR-1:0] r);
      for (int i = 1; i <= N_APPR; i++) begin
         int k;
         k = (from + i) % N_APPR;
         if (r[AW'(k)]) return k;
      end
      return 0;
   endfunction

   function automatic logic [2*N_APPR-1:0] model_sig();
      logic [2*N_APPR-1:0] v;
      v = '1;
      for (int k = 0; k < N_APPR; k++)
         if (k == m_active && m_state == 0) v[2*k +: 2] = 2'b01;
         else if (k == m_active && m_state == 1) v[2*k +: 2] = 2'b10;
      return v;
   endfunction

   function automatic logic [VW-1:0] model_vec();
      return {model_sig(), 2'(m_state), AW'(m_active), m_grant};
   endfunction

   initial begin : model_proc
      bit tick, oth;
      int nxt, tn;
      logic [N_APPR-1:0] others;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_state = 2; m_active = 0; m_ticks = 0; m_cyc = 0; m_grant = 1'b0;
         end else begin
            m_cyc++;
            tick   = (m_cyc % TICK_DIV) == 0;
            tn     = m_ticks + 1;
            others = req;
            others[AW'(m_active)] = 1'b0;
            oth     = |others;
            nxt     = m_state;
            m_grant = 1'b0;
            case (m_state)
               0: begin
                  if (preempt) nxt = 1;
                  else if (tick && tn >= GREEN_MIN && oth &&
                           (!req[AW'(m_active)] || tn >= GREEN_MAX)) nxt = 1;
                  else if (tick && tn >= GREEN_MIN && m_active != 0 && req == '0) nxt = 1;
               end
               1: if (tick && tn == YELLOW_T) nxt = 2;
               default: begin
                  if (!preempt && tick && tn == ALLRED_T) begin
                     nxt      = 0;
                     m_active = pick_next(m_active, req);
                     m_grant  = 1'b1;
                  end
               end
            endcase
            if (nxt != m_state) m_ticks = 0;
            else if (m_state == 2 && preempt) m_ticks = 0;
            else if (tick) m_ticks++;
            m_state = nxt;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Counts consecutive samples (starting with the current one) where sig==v.
   task automatic run_len(input logic [2*N_APPR-1:0] v, input int limit, output int n);
      n = 0;
      while (sig === v && n < limit) begin
         n++;
         cyc();
      end
   endtask

   task automatic wait_grant(input int limit, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < limit) begin
         cyc();
         n++;
         if (grant_pulse === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic apply_reset(output bit ok);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_grant(4*TICK_DIV, ok);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int n;
      rst = 1'b1; req = '0; preempt = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({sig, phase, active, grant_pulse} !== {8'hFF, 2'b10, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got %h want %h", {sig, phase, active, grant_pulse},
                  {8'hFF, 2'b10, 2'd0, 1'b0});
      end
      rst = 1'b0;
      run_len(8'hFF, 20, n);
      n_checks++;
      if (n !== 4) begin
         n_fail++; $display("FAIL release_red_cycles: got %0d want 4", n);
      end
      n_checks++;
      if ({sig, active, phase, grant_pulse} !== {8'hFD, 2'd0, 2'b00, 1'b1}) begin
         n_fail++;
         $display("FAIL home_green_entry: got %h want %h", {sig, active, phase, grant_pulse},
                  {8'hFD, 2'd0, 2'b00, 1'b1});
      end
      n_checks++;
      if ({sig, phase, active, grant_pulse} !== model_vec()) begin
         n_fail++; $display("FAIL home_entry_model: got %h want %h",
                            {sig, phase, active, grant_pulse}, model_vec());
      end
      cyc();
      n_checks++;
      if (grant_pulse !== 1'b0) begin
         n_fail++; $display("FAIL grant_one_cycle: got %b want 0", grant_pulse);
      end
      run_len(8'hFD, 250, n);
      n_checks++;
      if (n !== 250) begin
         n_fail++; $display("FAIL home_rest: got %0d green cycles want 250", n);
      end
   endtask

   task automatic test_grant_to_other();
      int n;
      bit ok;
      req = '0;
      apply_reset(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL g2o_reset_grant: got timeout want grant"); end
      req = 4'b0100;
      run_len(8'hFD, 1000, n);
      n_checks++;
      if (n !== 40) begin n_fail++; $display("FAIL g2o_green_len: got %0d want 40", n); end
      run_len(8'hFE, 100, n);
      n_checks++;
      if (n !== 12) begin n_fail++; $display("FAIL g2o_yellow_len: got %0d want 12", n); end
      run_len(8'hFF, 100, n);
      n_checks++;
      if (n !== 4) begin n_fail++; $display("FAIL g2o_allred_len: got %0d want 4", n); end
      n_checks++;
      if ({sig, active, grant_pulse} !== {8'hDF, 2'd2, 1'b1}) begin
         n_fail++; $display("FAIL g2o_grant: got %h want %h", {sig, active, grant_pulse},
                            {8'hDF, 2'd2, 1'b1});
      end
      n_checks++;
      if ({sig, phase, active, grant_pulse} !== model_vec()) begin
         n_fail++; $display("FAIL g2o_model: got %h want %h",
                            {sig, phase, active, grant_pulse}, model_vec());
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      req = 4'b1011;
      wait_grant(400, ok);
      n_checks++;
      if (!ok || {active, sig} !== {2'd3, 8'h7F}) begin
         n_fail++; $display("FAIL rr_to_3: got ok=%0d %h want %h", ok, {active, sig}, {2'd3, 8'h7F});
      end
      req = 4'b0011;
      wait_grant(400, ok);
      n_checks++;
      if (!ok || {active, sig} !== {2'd0, 8'hFD}) begin
         n_fail++; $display("FAIL rr_wrap_to_0: got ok=%0d %h want %h", ok, {active, sig}, {2'd0, 8'hFD});
      end
      wait_grant(400, ok);
      n_checks++;
      if (!ok || {active, sig} !== {2'd1, 8'hF7}) begin
         n_fail++; $display("FAIL rr_to_1: got ok=%0d %h want %h", ok, {active, sig}, {2'd1, 8'hF7});
      end
      n_checks++;
      if ({sig, phase, active, grant_pulse} !== model_vec()) begin
         n_fail++; $display("FAIL rr_model: got %h want %h",
                            {sig, phase, active, grant_pulse}, model_vec());
      end
   endtask

   task automatic test_extension();
      int n;
      bit ok;
      // Owner 1 keeps demanding while 3 waits: green runs the full max.
      req = 4'b1010;
      run_len(8'hF7, 500, n);
      n_checks++;
      if (n !== GREEN_MAX*TICK_DIV) begin
         n_fail++; $display("FAIL ext_max_green: got %0d want %0d", n, GREEN_MAX*TICK_DIV);
      end
      n_checks++;
      if (sig !== 8'hFB) begin n_fail++; $display("FAIL ext_yellow: got %h want FB", sig); end
      wait_grant(400, ok);
      n_checks++;
      if (!ok || active !== 2'd3) begin
         n_fail++; $display("FAIL ext_to_3: got ok=%0d active=%0d want 3", ok, active);
      end
      wait_grant(400, ok);
      n_checks++;
      if (!ok || active !== 2'd1) begin
         n_fail++; $display("FAIL ext_back_to_1: got ok=%0d active=%0d want 1", ok, active);
      end
      // Owner 1 drops its request before tick 15: yellow on tick 15.
      repeat (58) cyc();
      req = 4'b1000;
      run_len(8'hF7, 100, n);
      n_checks++;
      if (58 + n !== 60) begin
         n_fail++; $display("FAIL ext_early_drop: got %0d green cycles want 60", 58 + n);
      end
      n_checks++;
      if ({sig, phase, active, grant_pulse} !== model_vec()) begin
         n_fail++; $display("FAIL ext_model: got %h want %h",
                            {sig, phase, active, grant_pulse}, model_vec());
      end
   endtask

   task automatic test_preempt();
      int n, bad;
      bit ok;
      req = '0;
      apply_reset(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pre_reset_grant: got timeout want grant"); end
      repeat (2*TICK_DIV) cyc();
      preempt = 1'b1;
      cyc();
      preempt = 1'b0;
      n_checks++;
      if ({phase, sig} !== {2'b01, 8'hFE}) begin
         n_fail++; $display("FAIL pre_to_yellow: got %h want %h", {phase, sig}, {2'b01, 8'hFE});
      end
      // Yellow entered one cycle after a tick: 3 + 4 + 4 cycles to its 3rd tick.
      run_len(8'hFE, 100, n);
      n_checks++;
      if (n !== 11) begin n_fail++; $display("FAIL pre_yellow_len: got %0d want 11", n); end
      preempt = 1'b1;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         cyc();
         if (sig !== 8'hFF) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL pre_hold_red: got %0d non-red cycles want 0", bad); end
      preempt = 1'b0;
      run_len(8'hFF, 20, n);
      n_checks++;
      if (n < 1 || n > TICK_DIV) begin
         n_fail++; $display("FAIL pre_release_delay: got %0d want 1..%0d", n, TICK_DIV);
      end
      n_checks++;
      if ({sig, active, grant_pulse} !== {8'hFD, 2'd0, 1'b1}) begin
         n_fail++; $display("FAIL pre_release_home: got %h want %h", {sig, active, grant_pulse},
                            {8'hFD, 2'd0, 1'b1});
      end
      n_checks++;
      if ({sig, phase, active, grant_pulse} !== model_vec()) begin
         n_fail++; $display("FAIL pre_model: got %h want %h",
                            {sig, phase, active, grant_pulse}, model_vec());
      end
   endtask

   task automatic test_reset_mid_yellow();
      int n;
      bit ok;
      req = '0;
      apply_reset(ok);
      req = 4'b0100;
      wait_grant(200, ok);
      n_checks++;
      if (!ok || active !== 2'd2) begin
         n_fail++; $display("FAIL rmy_reach_2: got ok=%0d active=%0d want 2", ok, active);
      end
      preempt = 1'b1;
      cyc();
      preempt = 1'b0;
      n_checks++;
      if (sig !== 8'hEF) begin n_fail++; $display("FAIL rmy_yellow: got %h want EF", sig); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({sig, phase, active} !== {8'hFF, 2'b10, 2'd0}) begin
         n_fail++; $display("FAIL rmy_async_reset: got %h want %h", {sig, phase, active},
                            {8'hFF, 2'b10, 2'd0});
      end
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      run_len(8'hFF, 20, n);
      n_checks++;
      if (n !== 4 || {sig, active, grant_pulse} !== {8'hFD, 2'd0, 1'b1}) begin
         n_fail++; $display("FAIL rmy_resume: got red=%0d %h want red=4 %h", n,
                            {sig, active, grant_pulse}, {8'hFD, 2'd0, 1'b1});
      end
   endtask

   task automatic test_random();
      int hold, nr, exp_nr;
      bit ok;
      req = '0; preempt = 1'b0;
      apply_reset(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rnd_reset_grant: got timeout want grant"); end
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hold == 0) begin
            req  = ($urandom_range(0, 3) == 0) ? '0 : N_APPR'($urandom);
            hold = $urandom_range(1, 60);
         end else begin
            hold--;
         end
         if (preempt) begin
            if ($urandom_range(0, 7) == 0) preempt = 1'b0;
         end else if ($urandom_range(0, 149) == 0) begin
            preempt = 1'b1;
         end
         cyc();
         n_checks++;
         if ({sig, phase, active, grant_pulse} !== model_vec()) begin
            n_fail++; $display("FAIL rnd_model c=%0d: got %h want %h", c,
                               {sig, phase, active, grant_pulse}, model_vec());
         end
         nr = 0;
         for (int k = 0; k < N_APPR; k++) if (sig[2*k +: 2] !== 2'b11) nr++;
         exp_nr = (m_state == 2) ? 0 : 1;
         n_checks++;
         if (nr !== exp_nr) begin
            n_fail++; $display("FAIL rnd_one_lamp c=%0d: got %0d non-red want %0d", c, nr, exp_nr);
         end
      end
      preempt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_grant_to_other();
      test_round_robin();
      test_extension();
      test_preempt();
      test_reset_mid_yellow();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
